// File: rtl/seq_divider_if.sv
// seq_divider_if: start/ready handshake between the EX stage and the sequential divider.
interface seq_divider_if #(parameter int WIDTH = 32);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
                    input  result_o, ready_o);
    modport slave  (input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
                    output result_o, ready_o);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per cycle, result = {remainder, quotient}.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    seq_divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, DZERO, BUSY, DONE} state_t;
    state_t             state, state_n;
    logic [WIDTH-1:0]   rem, quo, dvs;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] result, result_n;
    logic               ready, ready_n;
    logic               a_neg, b_neg, go, last;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   rem_n, quo_n, q_fin, r_fin;
    assign a_neg   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign b_neg   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign go      = bus.start_i & ~bus.annul_i;
    assign last    = cnt == CW'(WIDTH - 1);
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    // A borrow out of the top bit means the trial subtraction failed: restore.
    assign rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_n   = {quo[WIDTH-2:0], ~diff[WIDTH]};
    assign q_fin   = neg_q ? -quo_n : quo_n;
    assign r_fin   = neg_r ? -rem_n : rem_n;
    assign bus.result_o = result;
    assign bus.ready_o  = ready;
    always_ff @(posedge clk)
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_n;
            ready  <= ready_n;
            result <= result_n;
        end
    always_comb begin
        state_n  = state;
        ready_n  = 1'b0;
        result_n = '0;
        unique case (state)
            IDLE:  state_n = go ? (bus.opdata2_i == '0 ? DZERO : BUSY) : IDLE;
            DZERO: begin
                state_n = bus.annul_i ? IDLE : DONE;
                ready_n = ~bus.annul_i;
            end
            BUSY: begin
                state_n  = bus.annul_i ? IDLE : (last ? DONE : BUSY);
                ready_n  = ~bus.annul_i & last;
                result_n = ready_n ? {r_fin, q_fin} : '0;
            end
            DONE: begin
                state_n  = (bus.annul_i | ~bus.start_i) ? IDLE : DONE;
                ready_n  = state_n == DONE;
                result_n = ready_n ? result : '0;
            end
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && go) begin
            rem   <= '0;
            quo   <= a_neg ? -bus.opdata1_i : bus.opdata1_i;
            dvs   <= b_neg ? -bus.opdata2_i : bus.opdata2_i;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (state == BUSY) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
        end
endmodule
